// File: rtl/buzzer_pkg.sv
// rtl/buzzer_pkg.sv - shared state type, note dividers and timing defaults for the buzzer arbiter
package buzzer_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PLAY = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   // Tone generator dividers for a 48 MHz system clock
   localparam logic [15:0] L_5 = 16'd61224;
   localparam logic [15:0] L_6 = 16'd54545;
   localparam logic [15:0] M_1 = 16'd45863;
   localparam logic [15:0] M_2 = 16'd40865;
   localparam logic [15:0] M_3 = 16'd36402;
   localparam logic [15:0] M_5 = 16'd30612;
   localparam logic [15:0] M_6 = 16'd27273;
   localparam logic [15:0] H_1 = 16'd22956;

   localparam int DEFAULT_TICK_CYCLES = 12_000_000;
   localparam int DEFAULT_GAP_CYCLES  = 480_000;

endpackage

// File: rtl/buzzer_arbiter_if.sv
// rtl/buzzer_arbiter_if.sv - requester/arbiter signal bundle for the buzzer arbiter
interface buzzer_arbiter_if #(
   parameter int NREQ  = 3,
   parameter int DIV_W = 16,
   parameter int DUR_W = 8
);
   logic [NREQ-1:0]       req;
   logic [NREQ*DIV_W-1:0] div_in;
   logic [NREQ*DUR_W-1:0] dur_in;
   logic [NREQ-1:0]       ack;
   logic [NREQ-1:0]       done;
   logic [NREQ-1:0]       abort;
   logic [NREQ-1:0]       owner;
   logic                  busy;
   logic                  tone_en;
   logic [DIV_W-1:0]      tone_div;

   modport master (
      output req, div_in, dur_in,
      input  ack, done, abort, owner, busy, tone_en, tone_div
   );

   modport slave (
      input  req, div_in, dur_in,
      output ack, done, abort, owner, busy, tone_en, tone_div
   );
endinterface

// File: rtl/cycle_timer.sv
// rtl/cycle_timer.sv - loadable down-counter that flags expiry after CYCLES enabled cycles
module cycle_timer #(
   parameter int CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic en,
   output logic expire
);
   localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

   logic [CW-1:0] count;

   // Holds at zero rather than wrapping; the owner reloads it on expiry
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= CW'(CYCLES - 1);
      end else if (en && (count != '0)) begin
         count <= count - CW'(1);
      end
   end

   assign expire = (count == '0);
endmodule

// File: rtl/buzzer_arbiter.sv
// rtl/buzzer_arbiter.sv - fixed-priority, preemptive arbiter sharing one tone generator
module buzzer_arbiter
   import buzzer_pkg::*;
#(
   parameter int NREQ        = 3,
   parameter int DIV_W       = 16,
   parameter int DUR_W       = 8,
   parameter int TICK_CYCLES = DEFAULT_TICK_CYCLES,
   parameter int GAP_CYCLES  = DEFAULT_GAP_CYCLES
) (
   input logic             sys_clk,
   input logic             sys_rst,
   buzzer_arbiter_if.slave bus
);
   state_t           state;
   logic [NREQ-1:0]  ack_q;
   logic [NREQ-1:0]  done_q;
   logic [NREQ-1:0]  abort_q;
   logic [NREQ-1:0]  owner_q;
   logic             tone_en_q;
   logic [DIV_W-1:0] tone_div_q;
   logic [DUR_W-1:0] remaining;

   logic [NREQ-1:0]  mask;
   logic [NREQ-1:0]  eligible;
   logic [NREQ-1:0]  win_oh;
   logic [DIV_W-1:0] win_div;
   logic [DUR_W-1:0] win_dur;
   logic             take;
   logic             tick_exp;
   logic             gap_exp;
   logic             tick_load;
   logic             gap_load;

   // Only requesters strictly above the owner may win; in IDLE owner is zero so all compete
   always_comb begin
      mask     = (owner_q == '0) ? {NREQ{1'b1}} : (owner_q - NREQ'(1));
      eligible = bus.req & mask;
      win_oh   = '0;
      win_div  = '0;
      win_dur  = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            win_oh  = NREQ'(1) << i;
            win_div = bus.div_in[i*DIV_W +: DIV_W];
            win_dur = bus.dur_in[i*DUR_W +: DUR_W];
         end
      end
      take = |eligible;
   end

   always_comb begin
      tick_load = 1'b0;
      gap_load  = 1'b0;
      if (take) begin
         tick_load = (win_dur != '0);
      end else if (state == S_PLAY && tick_exp) begin
         tick_load = (remaining != DUR_W'(1));
         gap_load  = (remaining == DUR_W'(1));
      end
   end

   cycle_timer #(.CYCLES(TICK_CYCLES)) u_tick_timer (
      .clk    (sys_clk),
      .rst    (sys_rst),
      .load   (tick_load),
      .en     (state == S_PLAY),
      .expire (tick_exp)
   );

   cycle_timer #(.CYCLES(GAP_CYCLES)) u_gap_timer (
      .clk    (sys_clk),
      .rst    (sys_rst),
      .load   (gap_load),
      .en     (state == S_GAP),
      .expire (gap_exp)
   );

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state      <= S_IDLE;
         ack_q      <= '0;
         done_q     <= '0;
         abort_q    <= '0;
         owner_q    <= '0;
         tone_en_q  <= 1'b0;
         tone_div_q <= '0;
         remaining  <= '0;
      end else begin
         ack_q   <= '0;
         done_q  <= '0;
         abort_q <= '0;
         if (take) begin
            ack_q      <= win_oh;
            tone_div_q <= win_div;
            remaining  <= win_dur;
            // A note still in GAP already reported done, so only PLAY is aborted
            if (state == S_PLAY) begin
               abort_q <= owner_q;
            end
            if (win_dur == '0) begin
               done_q    <= win_oh;
               owner_q   <= '0;
               tone_en_q <= 1'b0;
               state     <= S_IDLE;
            end else begin
               owner_q   <= win_oh;
               tone_en_q <= 1'b1;
               state     <= S_PLAY;
            end
         end else begin
            case (state)
               S_PLAY: begin
                  if (tick_exp) begin
                     remaining <= remaining - DUR_W'(1);
                     if (remaining == DUR_W'(1)) begin
                        tone_en_q <= 1'b0;
                        done_q    <= owner_q;
                        state     <= S_GAP;
                     end
                  end
               end
               S_GAP: begin
                  if (gap_exp) begin
                     owner_q <= '0;
                     state   <= S_IDLE;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.ack      = ack_q;
   assign bus.done     = done_q;
   assign bus.abort    = abort_q;
   assign bus.owner    = owner_q;
   assign bus.busy     = (state != S_IDLE);
   assign bus.tone_en  = tone_en_q;
   assign bus.tone_div = tone_div_q;
endmodule

// File: tb/tb_buzzer_arbiter.sv
// tb/tb_buzzer_arbiter.sv - directed, table-driven bench for buzzer_arbiter
module tb_buzzer_arbiter;
   import buzzer_pkg::*;

   logic sys_clk = 1'b0;
   logic sys_rst;
   int   checks = 0;
   int   errors = 0;

   always #5 sys_clk = ~sys_clk;

   buzzer_arbiter_if #(.NREQ(3), .DIV_W(16), .DUR_W(8)) bus ();

   buzzer_arbiter #(
      .NREQ(3), .DIV_W(16), .DUR_W(8), .TICK_CYCLES(4), .GAP_CYCLES(2)
   ) dut (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .bus     (bus.slave)
   );

   typedef struct {
      logic        rst;
      logic [2:0]  req;
      logic [2:0]  ack;
      logic [2:0]  done;
      logic [2:0]  abort;
      logic [2:0]  owner;
      logic        busy;
      logic        tone_en;
      logic [15:0] tone_div;
   } vec_t;

   vec_t vq[$];

   function automatic void add(input logic rst, input logic [2:0] req, input logic [2:0] ack,
                               input logic [2:0] done, input logic [2:0] abort,
                               input logic [2:0] owner, input logic busy,
                               input logic tone_en, input logic [15:0] tone_div);
      vec_t v;
      v.rst = rst; v.req = req; v.ack = ack; v.done = done; v.abort = abort;
      v.owner = owner; v.busy = busy; v.tone_en = tone_en; v.tone_div = tone_div;
      vq.push_back(v);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic [2:0] ack, input logic [2:0] done,
                             input logic [2:0] abort, input logic [2:0] owner,
                             input logic busy, input logic tone_en);
      check({tag, " ack"},     32'(bus.ack),     32'(ack));
      check({tag, " done"},    32'(bus.done),    32'(done));
      check({tag, " abort"},   32'(bus.abort),   32'(abort));
      check({tag, " owner"},   32'(bus.owner),   32'(owner));
      check({tag, " busy"},    32'(bus.busy),    32'(busy));
      check({tag, " tone_en"}, 32'(bus.tone_en), 32'(tone_en));
   endtask

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   initial begin
      sys_rst    = 1'b1;
      bus.req    = 3'b000;
      bus.div_in = {H_1, L_6, M_1};
      bus.dur_in = {8'd5, 8'd0, 8'd3};

      // Reset, single note (3 ticks of 4 cycles), gap of 2, then zero-duration request
      add(1'b1, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 16'd0);
      add(1'b0, 3'b001, 3'b001, 3'b000, 3'b000, 3'b001, 1'b1, 1'b1, M_1);
      for (int k = 2; k <= 12; k++)
         add(1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 1'b1, 1'b1, M_1);
      add(1'b0, 3'b000, 3'b000, 3'b001, 3'b000, 3'b001, 1'b1, 1'b0, 16'd0);
      add(1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 1'b1, 1'b0, 16'd0);
      add(1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 16'd0);
      add(1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 16'd0);
      add(1'b0, 3'b010, 3'b010, 3'b010, 3'b000, 3'b000, 1'b0, 1'b0, 16'd0);
      add(1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 16'd0);

      for (int r = 0; r < vq.size(); r++) begin
         sys_rst = vq[r].rst;
         bus.req = vq[r].req;
         step();
         check_outs($sformatf("row%0d", r), vq[r].ack, vq[r].done, vq[r].abort,
                    vq[r].owner, vq[r].busy, vq[r].tone_en);
         if (vq[r].tone_en || vq[r].rst)
            check($sformatf("row%0d tone_div", r), 32'(bus.tone_div), 32'(vq[r].tone_div));
      end

      // Simultaneous req[0] and req[2]: only 0 is acked, 2 waits for GAP->IDLE plus one cycle
      bus.req = 3'b101;
      step();
      check_outs("sim ack0", 3'b001, 3'b000, 3'b000, 3'b001, 1'b1, 1'b1);
      bus.req = 3'b100;
      for (int k = 1; k <= 11; k++) begin
         step();
         check($sformatf("sim play%0d ack", k), 32'(bus.ack), 32'd0);
         check($sformatf("sim play%0d tone_en", k), 32'(bus.tone_en), 32'd1);
      end
      step();
      check_outs("sim done", 3'b000, 3'b001, 3'b000, 3'b001, 1'b1, 1'b0);
      step();
      check_outs("sim gap", 3'b000, 3'b000, 3'b000, 3'b001, 1'b1, 1'b0);
      step();
      check_outs("sim idle", 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
      step();
      check_outs("sim ack2", 3'b100, 3'b000, 3'b000, 3'b100, 1'b1, 1'b1);
      check("sim ack2 tone_div", 32'(bus.tone_div), 32'(H_1));
      bus.req = 3'b000;

      // Preempt requester 2 (dur 5) during its 6th PLAY cycle
      for (int k = 2; k <= 6; k++) begin
         step();
         check($sformatf("pre play%0d tone_en", k), 32'(bus.tone_en), 32'd1);
         check($sformatf("pre play%0d tone_div", k), 32'(bus.tone_div), 32'(H_1));
      end
      bus.req = 3'b001;
      step();
      check_outs("preempt", 3'b001, 3'b000, 3'b100, 3'b001, 1'b1, 1'b1);
      check("preempt tone_div", 32'(bus.tone_div), 32'(M_1));

      // Lower-priority request waits through owner 0's full note and gap
      bus.dur_in = {8'd5, 8'd2, 8'd3};
      bus.req    = 3'b010;
      for (int k = 1; k <= 11; k++) begin
         step();
         check_outs($sformatf("low play%0d", k), 3'b000, 3'b000, 3'b000, 3'b001, 1'b1, 1'b1);
      end
      step();
      check_outs("low done", 3'b000, 3'b001, 3'b000, 3'b001, 1'b1, 1'b0);
      step();
      check_outs("low gap", 3'b000, 3'b000, 3'b000, 3'b001, 1'b1, 1'b0);
      step();
      check_outs("low idle", 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
      step();
      check_outs("low ack1", 3'b010, 3'b000, 3'b000, 3'b010, 1'b1, 1'b1);
      check("low ack1 tone_div", 32'(bus.tone_div), 32'(L_6));
      bus.req = 3'b000;

      // Reset in the middle of requester 1's note, with req[0] held through reset
      for (int k = 1; k <= 3; k++) begin
         step();
         check($sformatf("rst play%0d tone_en", k), 32'(bus.tone_en), 32'd1);
      end
      sys_rst = 1'b1;
      bus.req = 3'b001;
      step();
      check_outs("rst mid", 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
      check("rst mid tone_div", 32'(bus.tone_div), 32'd0);
      sys_rst = 1'b0;
      step();
      check_outs("rst ack0", 3'b001, 3'b000, 3'b000, 3'b001, 1'b1, 1'b1);
      check("rst ack0 tone_div", 32'(bus.tone_div), 32'(M_1));
      bus.req = 3'b000;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
